// File: rtl/key_cache_ctrl.sv
// key_cache_ctrl: hit/miss front end for the 4-entry SM4 round-key cache.
// Resolves tag lookups, picks fill victims (free entry first, then LRU),
// sequences fills from the key-expansion unit and touches the LRU recorder.
// Optional hit/miss counters are compiled in with `define KEY_CACHE_STATS_EN.
module key_cache_ctrl #(
    parameter int unsigned TAG_W = 32
) (
    input  logic             clk_i,
    input  logic             reset_n_i,
    input  logic             req_v_i,
    input  logic [TAG_W-1:0] req_tag_i,
    output logic             req_ready_o,
    output logic             resp_v_o,
    output logic [1:0]       resp_idx_o,
    output logic             resp_hit_o,
    input  logic             resp_ready_i,
    output logic             fill_v_o,
    output logic [1:0]       fill_idx_o,
    output logic [TAG_W-1:0] fill_tag_o,
    input  logic             fill_ready_i,
    input  logic             fill_done_i,
    input  logic             flush_i,
`ifdef KEY_CACHE_STATS_EN
    output logic [15:0]      hit_cnt_o,
    output logic [15:0]      miss_cnt_o,
`endif
    output logic [1:0]       lru_access1_o,
    output logic             lru_v1_o,
    output logic [1:0]       lru_access2_o,
    output logic             lru_v2_o,
    input  logic [1:0]       lru_replace_i
);

    typedef enum logic [1:0] {StIdle, StFillReq, StFillWait, StResp} state_e;

    state_e           state_q, state_d;
    logic [3:0]       valid_q, valid_d;
    logic [TAG_W-1:0] tag_q [4];
    logic [TAG_W-1:0] tag_d [4];
    logic [1:0]       victim_q, victim_d;
    logic [TAG_W-1:0] req_tag_q, req_tag_d;
    logic [1:0]       resp_idx_q, resp_idx_d;
    logic             resp_hit_q, resp_hit_d;

    logic [3:0] hit_vec;
    logic       hit_any;
    logic [1:0] hit_idx;
    logic [1:0] miss_victim;
    logic       accept;

    // Tag compare and victim choice: lowest free entry, else the LRU entry.
    always_comb begin
        hit_any     = 1'b0;
        hit_idx     = 2'd0;
        miss_victim = lru_replace_i;
        for (int i = 0; i < 4; i++) begin
            hit_vec[i] = valid_q[i] && (tag_q[i] == req_tag_i);
        end
        for (int i = 3; i >= 0; i--) begin
            if (hit_vec[i]) begin
                hit_any = 1'b1;
                hit_idx = 2'(i);
            end
            if (!valid_q[i]) begin
                miss_victim = 2'(i);
            end
        end
    end

    // Flush takes priority over a request in the same cycle.
    assign req_ready_o = (state_q == StIdle) && reset_n_i && !flush_i;
    assign accept      = req_v_i && req_ready_o;

    // State register and cache contents with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q    <= StIdle;
            valid_q    <= 4'b0;
            victim_q   <= 2'd0;
            req_tag_q  <= '0;
            resp_idx_q <= 2'd0;
            resp_hit_q <= 1'b0;
            for (int i = 0; i < 4; i++) tag_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            valid_q    <= valid_d;
            victim_q   <= victim_d;
            req_tag_q  <= req_tag_d;
            resp_idx_q <= resp_idx_d;
            resp_hit_q <= resp_hit_d;
            for (int i = 0; i < 4; i++) tag_q[i] <= tag_d[i];
        end
    end

    // Next-state and datapath updates.
    always_comb begin
        state_d    = state_q;
        valid_d    = valid_q;
        tag_d      = tag_q;
        victim_d   = victim_q;
        req_tag_d  = req_tag_q;
        resp_idx_d = resp_idx_q;
        resp_hit_d = resp_hit_q;
        unique case (state_q)
            StIdle: begin
                if (flush_i) begin
                    valid_d = 4'b0;
                end else if (accept) begin
                    if (hit_any) begin
                        resp_idx_d = hit_idx;
                        resp_hit_d = 1'b1;
                        state_d    = StResp;
                    end else begin
                        // Drop the victim now so a half-written entry never hits.
                        victim_d             = miss_victim;
                        req_tag_d            = req_tag_i;
                        valid_d[miss_victim] = 1'b0;
                        state_d              = StFillReq;
                    end
                end
            end
            StFillReq: begin
                if (fill_ready_i) state_d = StFillWait;
            end
            StFillWait: begin
                if (fill_done_i) begin
                    valid_d[victim_q] = 1'b1;
                    tag_d[victim_q]   = req_tag_q;
                    resp_idx_d        = victim_q;
                    resp_hit_d        = 1'b0;
                    state_d           = StResp;
                end
            end
            StResp: begin
                if (resp_ready_i) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs: handshakes from state, LRU touches as single-cycle pulses.
    always_comb begin
        resp_v_o      = (state_q == StResp);
        resp_idx_o    = resp_idx_q;
        resp_hit_o    = resp_hit_q;
        fill_v_o      = (state_q == StFillReq);
        fill_idx_o    = victim_q;
        fill_tag_o    = req_tag_q;
        lru_v1_o      = accept && hit_any;
        lru_access1_o = hit_idx;
        lru_v2_o      = (state_q == StFillWait) && fill_done_i;
        lru_access2_o = victim_q;
    end

`ifdef KEY_CACHE_STATS_EN
    logic [15:0] hit_cnt_q, hit_cnt_d;
    logic [15:0] miss_cnt_q, miss_cnt_d;

    // Saturating per-outcome counters; only reset clears them.
    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (accept && hit_any && (hit_cnt_q != 16'hFFFF)) hit_cnt_d = hit_cnt_q + 16'd1;
        if (accept && !hit_any && (miss_cnt_q != 16'hFFFF)) miss_cnt_d = miss_cnt_q + 16'd1;
    end

    // Counter registers.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            hit_cnt_q  <= 16'd0;
            miss_cnt_q <= 16'd0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign hit_cnt_o  = hit_cnt_q;
    assign miss_cnt_o = miss_cnt_q;
`endif

endmodule

// File: tb/tb_key_cache_ctrl.sv
// Testbench for key_cache_ctrl: directed requests with a response scoreboard.
module tb_key_cache_ctrl;

    localparam int unsigned TAG_W = 32;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             req_v = 1'b0;
    logic [TAG_W-1:0] req_tag = '0;
    logic             req_ready;
    logic             resp_v;
    logic [1:0]       resp_idx;
    logic             resp_hit;
    logic             resp_ready = 1'b0;
    logic             fill_v;
    logic [1:0]       fill_idx;
    logic [TAG_W-1:0] fill_tag;
    logic             fill_ready = 1'b0;
    logic             fill_done = 1'b0;
    logic             flush = 1'b0;
    logic [1:0]       lru_access1;
    logic             lru_v1;
    logic [1:0]       lru_access2;
    logic             lru_v2;
    logic [1:0]       lru_replace = 2'd0;
`ifdef KEY_CACHE_STATS_EN
    logic [15:0]      hit_cnt;
    logic [15:0]      miss_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    logic [2:0] exp_q [$];

    key_cache_ctrl #(.TAG_W(TAG_W)) dut (
        .clk_i        (clk),
        .reset_n_i    (reset_n),
        .req_v_i      (req_v),
        .req_tag_i    (req_tag),
        .req_ready_o  (req_ready),
        .resp_v_o     (resp_v),
        .resp_idx_o   (resp_idx),
        .resp_hit_o   (resp_hit),
        .resp_ready_i (resp_ready),
        .fill_v_o     (fill_v),
        .fill_idx_o   (fill_idx),
        .fill_tag_o   (fill_tag),
        .fill_ready_i (fill_ready),
        .fill_done_i  (fill_done),
        .flush_i      (flush),
`ifdef KEY_CACHE_STATS_EN
        .hit_cnt_o    (hit_cnt),
        .miss_cnt_o   (miss_cnt),
`endif
        .lru_access1_o(lru_access1),
        .lru_v1_o     (lru_v1),
        .lru_access2_o(lru_access2),
        .lru_v2_o     (lru_v2),
        .lru_replace_i(lru_replace)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every response handshake is checked against the scoreboard.
    always @(negedge clk) begin
        #2;
        if (resp_v && resp_ready) begin
            if (exp_q.size() == 0) begin
                chk("resp_unexpected", 32'd1, 32'd0);
            end else begin
                logic [2:0] e;
                e = exp_q.pop_front();
                chk("resp_hit", {31'd0, resp_hit}, {31'd0, e[2]});
                chk("resp_idx", {30'd0, resp_idx}, {30'd0, e[1:0]});
            end
        end
        if (lru_v1 && lru_v2) begin
            n_fail++;
            $display("FAIL lru_both: got v1=1 v2=1, expected at most one");
        end
        if ($countones(dut.hit_vec) > 1) begin
            n_fail++;
            $display("FAIL multi_hit: got %b, expected one-hot", dut.hit_vec);
        end
    end

    // One full request: accept, optional fill with stall, response with stall.
    task automatic do_req(input logic [TAG_W-1:0] tag, input logic hit, input logic [1:0] idx,
                          input int fstall, input int rstall);
        @(negedge clk);
        req_v   = 1'b1;
        req_tag = tag;
        #1;
        chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
        chk("lru_v1_accept", {31'd0, lru_v1}, {31'd0, hit});
        if (hit) chk("lru_access1", {30'd0, lru_access1}, {30'd0, idx});
        exp_q.push_back({hit, idx});
        @(negedge clk);
        req_v = 1'b0;
        if (!hit) begin
            for (int i = 0; i <= fstall; i++) begin
                #1;
                chk("fill_v", {31'd0, fill_v}, 32'd1);
                chk("fill_idx", {30'd0, fill_idx}, {30'd0, idx});
                chk("fill_tag", fill_tag, tag);
                chk("req_ready_fill", {31'd0, req_ready}, 32'd0);
                if (i == fstall) fill_ready = 1'b1;
                @(negedge clk);
            end
            fill_ready = 1'b0;
            #1;
            chk("fill_v_wait", {31'd0, fill_v}, 32'd0);
            chk("lru_v2_idle", {31'd0, lru_v2}, 32'd0);
            @(negedge clk);
            fill_done = 1'b1;
            #1;
            chk("lru_v2_done", {31'd0, lru_v2}, 32'd1);
            chk("lru_access2", {30'd0, lru_access2}, {30'd0, idx});
            @(negedge clk);
            fill_done = 1'b0;
        end
        for (int i = 0; i <= rstall; i++) begin
            #1;
            chk("resp_v", {31'd0, resp_v}, 32'd1);
            chk("resp_idx_hold", {30'd0, resp_idx}, {30'd0, idx});
            chk("resp_hit_hold", {31'd0, resp_hit}, {31'd0, hit});
            chk("req_ready_resp", {31'd0, req_ready}, 32'd0);
            if (i == rstall) resp_ready = 1'b1;
            @(negedge clk);
        end
        resp_ready = 1'b0;
        #1;
        chk("resp_v_done", {31'd0, resp_v}, 32'd0);
        chk("req_ready_back", {31'd0, req_ready}, 32'd1);
    endtask

    initial begin
        // Reset state.
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_resp_v", {31'd0, resp_v}, 32'd0);
        chk("rst_fill_v", {31'd0, fill_v}, 32'd0);
        chk("rst_lru_v1", {31'd0, lru_v1}, 32'd0);
        chk("rst_lru_v2", {31'd0, lru_v2}, 32'd0);
        chk("rst_resp_idx", {30'd0, resp_idx}, 32'd0);
        chk("rst_fill_idx", {30'd0, fill_idx}, 32'd0);
        chk("rst_resp_hit", {31'd0, resp_hit}, 32'd0);
        reset_n = 1'b1;
        #1;
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);

        // First miss fills entry 0.
        do_req(32'hA5, 1'b0, 2'd0, 0, 0);

        // Flush beats a simultaneous request.
        @(negedge clk);
        flush   = 1'b1;
        req_v   = 1'b1;
        req_tag = 32'hA5;
        #1;
        chk("flush_req_ready", {31'd0, req_ready}, 32'd0);
        chk("flush_lru_v1", {31'd0, lru_v1}, 32'd0);
        @(negedge clk);
        flush = 1'b0;
        req_v = 1'b0;

        // Fill all four entries, entry 0 first since the flush freed it.
        do_req(32'h1, 1'b0, 2'd0, 0, 0);
        do_req(32'h2, 1'b0, 2'd1, 0, 0);
        do_req(32'h3, 1'b0, 2'd2, 0, 0);
        do_req(32'h4, 1'b0, 2'd3, 0, 0);
        do_req(32'h3, 1'b1, 2'd2, 0, 3);

        // Full cache: victims come from the LRU recorder.
        lru_replace = 2'd1;
        do_req(32'h9, 1'b0, 2'd1, 5, 0);
        lru_replace = 2'd3;
        do_req(32'h2, 1'b0, 2'd3, 0, 0);
        do_req(32'h9, 1'b1, 2'd1, 0, 0);
        do_req(32'h1, 1'b1, 2'd0, 0, 1);
        do_req(32'h3, 1'b1, 2'd2, 0, 0);

        // Reset while waiting for fill_done abandons the fill.
        lru_replace = 2'd0;
        @(negedge clk);
        req_v   = 1'b1;
        req_tag = 32'h55;
        @(negedge clk);
        req_v = 1'b0;
        #1;
        chk("abort_fill_v", {31'd0, fill_v}, 32'd1);
        chk("abort_fill_idx", {30'd0, fill_idx}, 32'd0);
        fill_ready = 1'b1;
        @(negedge clk);
        fill_ready = 1'b0;
        #1;
        chk("abort_wait_fill_v", {31'd0, fill_v}, 32'd0);
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        #1;
        chk("abort_fill_v_rst", {31'd0, fill_v}, 32'd0);
        chk("abort_resp_v_rst", {31'd0, resp_v}, 32'd0);
        reset_n = 1'b1;
        #1;
        chk("abort_req_ready", {31'd0, req_ready}, 32'd1);

        // Everything was invalidated: former hits now miss into free entries.
        do_req(32'h9, 1'b0, 2'd0, 0, 0);
        do_req(32'h3, 1'b0, 2'd1, 0, 0);

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/key_cache_ctrl.md
Name: key_cache_ctrl

Overview:
Front-end controller for the 4-entry round-key cache of the SM4 engine. It takes key-tag lookup requests, resolves hit or miss against 4 tag/valid entries, and on a miss selects a victim and sequences a round-key fill from the key-expansion unit. It drives the access/valid inputs of the 4-way LRU recorder (hits on port 1, fills on port 2) and consumes its replace-which output to pick victims.

Parameters:
TAG_W, 32, width of the key tag compared per entry

Ports:
clk_i  in  1  clock
reset_n_i  in  1  synchronous, active-low reset
req_v_i  in  1  lookup request valid
req_tag_i  in  TAG_W  key tag to look up
req_ready_o  out  1  request accepted when req_v_i and req_ready_o are both high
resp_v_o  out  1  response valid
resp_idx_o  out  2  entry holding the round keys for the request
resp_hit_o  out  1  1 = hit, 0 = entry was just filled
resp_ready_i  in  1  response consumed
fill_v_o  out  1  fill request to the key-expansion unit
fill_idx_o  out  2  entry to be filled
fill_tag_o  out  TAG_W  tag being filled
fill_ready_i  in  1  key-expansion unit accepts the fill
fill_done_i  in  1  one-cycle pulse: the fill has been written into the entry
flush_i  in  1  invalidate all entries
lru_access1_o  out  2  LRU recorder port 1 index (hit touch)
lru_v1_o  out  1  LRU recorder port 1 valid
lru_access2_o  out  2  LRU recorder port 2 index (fill touch)
lru_v2_o  out  1  LRU recorder port 2 valid
lru_replace_i  in  2  least-recently-used entry from the LRU recorder

Behaviour:
- Reset (reset_n_i=0 at a clock edge): all valid bits=0, tags=0, state=IDLE. Outputs: resp_v_o=0, fill_v_o=0, lru_v1_o=0, lru_v2_o=0, resp_idx_o/fill_idx_o=0, resp_hit_o=0. req_ready_o=1 starting the first cycle after reset is released. Reset in any state abandons the operation; an outstanding fill is dropped and fill_v_o falls immediately.
- States: IDLE, FILL_REQ, FILL_WAIT, RESP.
- IDLE: req_ready_o=1. On accept, the tag is compared combinationally against all valid entries.
  - Hit on entry k: next cycle enter RESP with resp_idx_o=k, resp_hit_o=1. lru_v1_o=1 and lru_access1_o=k for exactly one cycle, in the accept cycle.
  - Miss: latch the victim and the tag, then enter FILL_REQ. Victim = lowest-index invalid entry if any entry is invalid; otherwise lru_replace_i sampled in the accept cycle.
  - Tags are unique across valid entries, so multiple hits cannot occur. The bench asserts this.
- FILL_REQ: fill_v_o=1, fill_idx_o=victim, fill_tag_o=tag, all held stable until fill_ready_i=1, then enter FILL_WAIT.
- FILL_WAIT: wait for fill_done_i. On the pulse:
  - valid[victim]=1 and tag[victim]=tag.
  - lru_v2_o=1 and lru_access2_o=victim for one cycle.
  - Enter RESP with resp_hit_o=0.
  - The victim's valid bit is cleared on entry to FILL_REQ, so a partial fill is never reported as a hit.
- RESP: resp_v_o=1, with idx/hit held stable until resp_ready_i=1; then return to IDLE. req_ready_o=0 in every state except IDLE.
- Minimum latency: hit = response 1 cycle after accept. Miss = 1 + fill handshake + fill_done latency + 1.
- lru_v1_o and lru_v2_o are never high in the same cycle. The recorder gives port 1 priority.
- flush_i: acts only in IDLE with no request accepted in the same cycle; flush wins and req_ready_o=0 that cycle. All valid bits clear next cycle. flush_i in other states is ignored; the requester must retry.
- fill_done_i outside FILL_WAIT is ignored. fill_ready_i outside FILL_REQ is ignored.

Optional Feature:
KEY_CACHE_STATS_EN:
- Defined: adds outputs hit_cnt_o[15:0] and miss_cnt_o[15:0].
  - Each increments once per accepted request, by outcome.
  - Each saturates at 16'hFFFF.
  - Both clear on reset only; flush does not clear them.
- Undefined: ports and counters are absent, and behaviour is otherwise identical.

Test Plan:
- Reset, then req tag=0xA5 -> miss, fill_v_o=1 with fill_idx_o=0; after fill_done_i -> lru_v2_o=1 with access2=0; resp idx=0, hit=0.
- Fill tags 0x1, 0x2, 0x3, 0x4 into entries 0-3, then request 0x3 -> resp next cycle with idx=2, hit=1; lru_v1_o pulse with access1=2.
- Cache full, lru_replace_i=1, request 0x9 -> fill_idx_o=1; a subsequent lookup of the old tag 0x2 misses.
- Hold fill_ready_i=0 for 5 cycles -> fill_v_o, idx and tag stable; req_ready_o=0 throughout. Hold resp_ready_i=0 for 3 cycles -> resp stable.
- flush_i in IDLE with req_v_i=1 -> request not accepted, all valid cleared; next request for 0x1 misses and fills entry 0.
- Assert reset_n_i=0 during FILL_WAIT -> fill_v_o=0 and resp_v_o=0 next cycle, all entries invalid, req_ready_o=1 after release.
